// File: rtl/dmem_write_buffer_pkg.sv
// rtl/dmem_write_buffer_pkg.sv - shared types and sizes for the data-memory store buffer
// Purpose: entry record and default geometry used by dmem_write_buffer and its users.
// Ports: none (package).
package dmem_pkg;

  localparam int WBUF_N     = 64;
  localparam int WBUF_DEPTH = 4;
  localparam int WBUF_PTR_W = $clog2(WBUF_DEPTH);

  typedef struct packed {
    logic [WBUF_N-1:0] addr;
    logic [WBUF_N-1:0] data;
  } wbuf_entry_t;

endpackage

// File: rtl/dmem_write_buffer_if.sv
// rtl/dmem_write_buffer_if.sv - backing-memory bus between the store buffer and data memory
// Purpose: groups the memory read port and the req/ack drain port.
// Ports: mem_rd_addr/mem_rd_data (combinational read), mem_wr_req/addr/data/ack (drain handshake).
//   master = store buffer side, slave = memory side.
interface dmem_write_buffer_if #(parameter int N = dmem_pkg::WBUF_N);

  logic [N-1:0] mem_rd_addr;
  logic [N-1:0] mem_rd_data;
  logic         mem_wr_req;
  logic [N-1:0] mem_wr_addr;
  logic [N-1:0] mem_wr_data;
  logic         mem_wr_ack;

  modport master (
    output mem_rd_addr, mem_wr_req, mem_wr_addr, mem_wr_data,
    input  mem_rd_data, mem_wr_ack
  );

  modport slave (
    input  mem_rd_addr, mem_wr_req, mem_wr_addr, mem_wr_data,
    output mem_rd_data, mem_wr_ack
  );

endinterface

// File: rtl/dmem_write_buffer_fwd_match.sv
// rtl/dmem_write_buffer_fwd_match.sv - youngest-match store-to-load forwarding lookup
// Purpose: wbuf_fwd_match, combinational priority match of a load address against buffer entries.
// Ports: addr (load address), entry_addr/entry_data (storage), valid (per-entry valid),
//   tail (next write slot), hit (some valid entry matches), hit_data (youngest matching data).
module wbuf_fwd_match #(
  parameter int N     = 64,
  parameter int DEPTH = 4,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic [N-1:0]     addr,
  input  logic [N-1:0]     entry_addr [DEPTH],
  input  logic [N-1:0]     entry_data [DEPTH],
  input  logic [DEPTH-1:0] valid,
  input  logic [PTR_W-1:0] tail,
  output logic             hit,
  output logic [N-1:0]     hit_data
);

  // Walk from the oldest slot (tail-DEPTH) to the youngest (tail-1); later
  // matches overwrite earlier ones so the youngest store wins.
  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    for (int k = DEPTH; k >= 1; k--) begin
      if (valid[tail - PTR_W'(k)] && (entry_addr[tail - PTR_W'(k)] == addr)) begin
        hit      = 1'b1;
        hit_data = entry_data[tail - PTR_W'(k)];
      end
    end
  end

endmodule

// File: rtl/dmem_write_buffer.sv
// rtl/dmem_write_buffer.sv - MEM-stage store buffer with load forwarding and req/ack drain
// Purpose: single-cycle stores queued in a circular FIFO, drained to memory; loads forward
//   from the youngest pending store. Optional macro WBUF_COALESCE_EN merges a store into the
//   youngest entry when the addresses match.
// Ports: clk, reset (async, active-high); DM_addr/DM_writeData/DM_writeEnable/DM_readEnable in,
//   DM_readData out; mem (memory bus, master side); wbuf_full, wbuf_empty, wbuf_stall,
//   wbuf_overflow (sticky) status outputs.
module dmem_write_buffer
  import dmem_pkg::*;
#(
  parameter int N     = WBUF_N,
  parameter int DEPTH = WBUF_DEPTH
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N-1:0]         DM_addr,
  input  logic [N-1:0]         DM_writeData,
  input  logic                 DM_writeEnable,
  input  logic                 DM_readEnable,
  output logic [N-1:0]         DM_readData,
  dmem_write_buffer_if.master  mem,
  output logic                 wbuf_full,
  output logic                 wbuf_empty,
  output logic                 wbuf_stall,
  output logic                 wbuf_overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [N-1:0]     entry_addr [DEPTH];
  logic [N-1:0]     entry_data [DEPTH];
  logic [DEPTH-1:0] valid;
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] count;
  logic             overflow_q;

  logic req;
  logic drain;
  logic enq;
  logic coalesce;
  logic fwd_hit;
  logic [N-1:0] fwd_data;

  // The load result is produced every cycle whether or not a load is issued.
  logic unused_read_enable;
  assign unused_read_enable = DM_readEnable;

  assign wbuf_full  = (count == CNT_W'(DEPTH));
  assign wbuf_empty = (count == '0);
  assign wbuf_stall = DM_writeEnable & wbuf_full & ~mem.mem_wr_ack;

  assign req   = ~wbuf_empty;
  assign drain = req & mem.mem_wr_ack;

`ifdef WBUF_COALESCE_EN
  logic [PTR_W-1:0] youngest;
  assign youngest = tail - PTR_W'(1);
  // Merge into the youngest entry unless it is the head leaving this cycle;
  // then the store must get a fresh slot so the new data is not lost.
  assign coalesce = DM_writeEnable & req & (entry_addr[youngest] == DM_addr)
                    & ~((youngest == head) & mem.mem_wr_ack);
`else
  assign coalesce = 1'b0;
`endif

  // A full buffer still accepts a store when the head drains at the same edge.
  assign enq = DM_writeEnable & ~coalesce & ~wbuf_stall;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      valid      <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (drain) begin
        head        <= head + PTR_W'(1);
        valid[head] <= 1'b0;
      end
      // Ordered after the drain clear: when full, tail and head share a slot.
      if (enq) begin
        tail        <= tail + PTR_W'(1);
        valid[tail] <= 1'b1;
      end
      count <= count + CNT_W'(enq) - CNT_W'(drain);
      if (wbuf_stall & ~coalesce) begin
        overflow_q <= 1'b1;
      end
    end
  end

  // Payload storage needs no reset; the valid bits qualify it.
  always_ff @(posedge clk) begin
    if (enq) begin
      entry_addr[tail] <= DM_addr;
      entry_data[tail] <= DM_writeData;
    end
`ifdef WBUF_COALESCE_EN
    else if (coalesce) begin
      entry_data[youngest] <= DM_writeData;
    end
`endif
  end

  wbuf_fwd_match #(
    .N     (N),
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_fwd_match (
    .addr       (DM_addr),
    .entry_addr (entry_addr),
    .entry_data (entry_data),
    .valid      (valid),
    .tail       (tail),
    .hit        (fwd_hit),
    .hit_data   (fwd_data)
  );

  assign DM_readData     = fwd_hit ? fwd_data : mem.mem_rd_data;
  assign wbuf_overflow   = overflow_q;

  assign mem.mem_rd_addr = DM_addr;
  assign mem.mem_wr_req  = req;
  assign mem.mem_wr_addr = entry_addr[head];
  assign mem.mem_wr_data = entry_data[head];

endmodule

// File: tb/tb_dmem_write_buffer.sv
// tb/tb_dmem_write_buffer.sv - self-checking bench for dmem_write_buffer
module tb_dmem_write_buffer;
  import dmem_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] DM_addr;
  logic [63:0] DM_writeData;
  logic        DM_writeEnable;
  logic        DM_readEnable;
  logic [63:0] DM_readData;
  logic        wbuf_full, wbuf_empty, wbuf_stall, wbuf_overflow;

  int tests = 0;
  int fails = 0;

  dmem_write_buffer_if #(.N(64)) mif ();

  // Backing memory contents: every word reads as its address plus 0x1000.
  assign mif.mem_rd_data = mif.mem_rd_addr + 64'h1000;

  dmem_write_buffer #(.N(64), .DEPTH(4)) dut (
    .clk            (clk),
    .reset          (reset),
    .DM_addr        (DM_addr),
    .DM_writeData   (DM_writeData),
    .DM_writeEnable (DM_writeEnable),
    .DM_readEnable  (DM_readEnable),
    .DM_readData    (DM_readData),
    .mem            (mif),
    .wbuf_full      (wbuf_full),
    .wbuf_empty     (wbuf_empty),
    .wbuf_stall     (wbuf_stall),
    .wbuf_overflow  (wbuf_overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we, re, ack;
    wbuf_entry_t st;
    logic [63:0] rdata;
    logic        req;
    logic [63:0] waddr, wdata;
    logic        full, empty, stall, ovf;
  } vec_t;

  vec_t vecs[24];

  function automatic vec_t mk(logic we, logic re, logic ack, logic [63:0] a, logic [63:0] d,
                              logic [63:0] rdata, logic req, logic [63:0] waddr,
                              logic [63:0] wdata, logic full, logic empty, logic stall,
                              logic ovf);
    vec_t v;
    v.we = we; v.re = re; v.ack = ack;
    v.st.addr = a; v.st.data = d;
    v.rdata = rdata; v.req = req; v.waddr = waddr; v.wdata = wdata;
    v.full = full; v.empty = empty; v.stall = stall; v.ovf = ovf;
    return v;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(logic we, logic re, logic ack, logic [63:0] a, logic [63:0] d);
    @(negedge clk);
    DM_writeEnable = we;
    DM_readEnable  = re;
    mif.mem_wr_ack = ack;
    DM_addr        = a;
    DM_writeData   = d;
    #1;
  endtask

  initial begin
    reset = 1'b1;
    DM_writeEnable = 1'b0; DM_readEnable = 1'b0; mif.mem_wr_ack = 1'b0;
    DM_addr = '0; DM_writeData = '0;

    //        we re ack addr   wdata   rdata   req waddr  wdata  full empty stall ovf
    vecs[0]  = mk(1, 0, 0, 64'h10, 64'hAA, 64'h1010, 0, 64'h0,  64'h0,  0, 1, 0, 0);
    vecs[1]  = mk(0, 1, 0, 64'h10, 64'h0,  64'hAA,   1, 64'h10, 64'hAA, 0, 0, 0, 0);
    vecs[2]  = mk(0, 1, 1, 64'h10, 64'h0,  64'hAA,   1, 64'h10, 64'hAA, 0, 0, 0, 0);
    vecs[3]  = mk(0, 1, 0, 64'h10, 64'h0,  64'h1010, 0, 64'h0,  64'h0,  0, 1, 0, 0);
    vecs[4]  = mk(1, 0, 0, 64'h20, 64'h1,  64'h1020, 0, 64'h0,  64'h0,  0, 1, 0, 0);
    vecs[5]  = mk(1, 1, 0, 64'h20, 64'h2,  64'h1,    1, 64'h20, 64'h1,  0, 0, 0, 0);
`ifdef WBUF_COALESCE_EN
    vecs[6]  = mk(0, 1, 0, 64'h20, 64'h0,  64'h2,    1, 64'h20, 64'h2,  0, 0, 0, 0);
    vecs[7]  = mk(0, 1, 1, 64'h20, 64'h0,  64'h2,    1, 64'h20, 64'h2,  0, 0, 0, 0);
    vecs[8]  = mk(0, 1, 1, 64'h20, 64'h0,  64'h1020, 0, 64'h0,  64'h0,  0, 1, 0, 0);
`else
    vecs[6]  = mk(0, 1, 0, 64'h20, 64'h0,  64'h2,    1, 64'h20, 64'h1,  0, 0, 0, 0);
    vecs[7]  = mk(0, 1, 1, 64'h20, 64'h0,  64'h2,    1, 64'h20, 64'h1,  0, 0, 0, 0);
    vecs[8]  = mk(0, 1, 1, 64'h20, 64'h0,  64'h2,    1, 64'h20, 64'h2,  0, 0, 0, 0);
`endif
    vecs[9]  = mk(0, 1, 0, 64'h20, 64'h0,  64'h1020, 0, 64'h0,  64'h0,  0, 1, 0, 0);
    vecs[10] = mk(1, 0, 0, 64'h30, 64'hB0, 64'h1030, 0, 64'h0,  64'h0,  0, 1, 0, 0);
    vecs[11] = mk(1, 0, 0, 64'h31, 64'hB1, 64'h1031, 1, 64'h30, 64'hB0, 0, 0, 0, 0);
    vecs[12] = mk(1, 0, 0, 64'h32, 64'hB2, 64'h1032, 1, 64'h30, 64'hB0, 0, 0, 0, 0);
    vecs[13] = mk(1, 0, 0, 64'h33, 64'hB3, 64'h1033, 1, 64'h30, 64'hB0, 0, 0, 0, 0);
    vecs[14] = mk(1, 0, 0, 64'h34, 64'hB4, 64'h1034, 1, 64'h30, 64'hB0, 1, 0, 1, 0);
    vecs[15] = mk(0, 1, 0, 64'h34, 64'h0,  64'h1034, 1, 64'h30, 64'hB0, 1, 0, 0, 1);
    vecs[16] = mk(0, 1, 0, 64'h33, 64'h0,  64'hB3,   1, 64'h30, 64'hB0, 1, 0, 0, 1);
    vecs[17] = mk(1, 0, 1, 64'h40, 64'hC0, 64'h1040, 1, 64'h30, 64'hB0, 1, 0, 0, 1);
    vecs[18] = mk(0, 1, 0, 64'h40, 64'h0,  64'hC0,   1, 64'h31, 64'hB1, 1, 0, 0, 1);
    vecs[19] = mk(0, 0, 1, 64'h40, 64'h0,  64'hC0,   1, 64'h31, 64'hB1, 1, 0, 0, 1);
    vecs[20] = mk(0, 0, 1, 64'h40, 64'h0,  64'hC0,   1, 64'h32, 64'hB2, 0, 0, 0, 1);
    vecs[21] = mk(0, 0, 1, 64'h40, 64'h0,  64'hC0,   1, 64'h33, 64'hB3, 0, 0, 0, 1);
    vecs[22] = mk(0, 0, 1, 64'h40, 64'h0,  64'hC0,   1, 64'h40, 64'hC0, 0, 0, 0, 1);
    vecs[23] = mk(0, 0, 0, 64'h40, 64'h0,  64'h1040, 0, 64'h0,  64'h0,  0, 1, 0, 1);

    repeat (2) @(negedge clk);
    #1;
    chk("reset_req",   mif.mem_wr_req, 0);
    chk("reset_empty", wbuf_empty,     1);
    chk("reset_full",  wbuf_full,      0);
    chk("reset_ovf",   wbuf_overflow,  0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 24; i++) begin
      drive(vecs[i].we, vecs[i].re, vecs[i].ack, vecs[i].st.addr, vecs[i].st.data);
      chk($sformatf("v%0d_rdata", i), DM_readData,    vecs[i].rdata);
      chk($sformatf("v%0d_req", i),   mif.mem_wr_req, 64'(vecs[i].req));
      if (vecs[i].req) begin
        chk($sformatf("v%0d_waddr", i), mif.mem_wr_addr, vecs[i].waddr);
        chk($sformatf("v%0d_wdata", i), mif.mem_wr_data, vecs[i].wdata);
      end
      chk($sformatf("v%0d_full", i),  wbuf_full,     64'(vecs[i].full));
      chk($sformatf("v%0d_empty", i), wbuf_empty,    64'(vecs[i].empty));
      chk($sformatf("v%0d_stall", i), wbuf_stall,    64'(vecs[i].stall));
      chk($sformatf("v%0d_ovf", i),   wbuf_overflow, 64'(vecs[i].ovf));
    end

    // Asynchronous reset with two stores pending.
    drive(1, 0, 0, 64'h60, 64'hD0);
    drive(1, 0, 0, 64'h61, 64'hD1);
    drive(0, 0, 0, 64'h0, 64'h0);
    chk("pre_rst_req", mif.mem_wr_req, 1);
    reset = 1'b1;
    #1;
    chk("rst_req",   mif.mem_wr_req, 0);
    chk("rst_empty", wbuf_empty,     1);
    chk("rst_ovf",   wbuf_overflow,  0);
    @(negedge clk);
    reset = 1'b0;

    // Six stores with ack held high: pointers wrap, occupancy stays at one.
    for (int i = 0; i < 6; i++) begin
      drive(1, 0, 1, 64'h50 + 64'(i), 64'h500 + 64'(i));
      if (i == 0) begin
        chk("wrap0_req", mif.mem_wr_req, 0);
      end else begin
        chk($sformatf("wrap%0d_req", i),   mif.mem_wr_req,  1);
        chk($sformatf("wrap%0d_waddr", i), mif.mem_wr_addr, 64'h50 + 64'(i - 1));
        chk($sformatf("wrap%0d_wdata", i), mif.mem_wr_data, 64'h500 + 64'(i - 1));
        chk($sformatf("wrap%0d_full", i),  wbuf_full,       0);
      end
    end
    drive(0, 0, 1, 64'h0, 64'h0);
    chk("wrap_last_waddr", mif.mem_wr_addr, 64'h55);
    chk("wrap_last_wdata", mif.mem_wr_data, 64'h505);
    drive(0, 0, 0, 64'h0, 64'h0);
    chk("wrap_done_empty", wbuf_empty,     1);
    chk("wrap_done_req",   mif.mem_wr_req, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
